// File: rtl/coin_refunder.sv
// Quarter-return controller: one timed eject pulse per coin, waits for drop-sensor confirmation, faults on jam.
// Request accepted on the sampling edge (EJECT next cycle); per-coin period >= PULSE_CYC+1+GAP_CYC; new requests ignored unless IDLE.
module coin_refunder #(
  parameter int CNT_W       = 4,
  parameter int PULSE_CYC   = 4,
  parameter int GAP_CYC     = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             refundReq,
  input  logic [CNT_W-1:0] refundQty,
  input  logic             coinSeen,
  input  logic             clrFault,
  output logic             eject,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] remaining
);

  localparam int MAXA = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int MAXC = (MAXA > ACK_TIMEOUT) ? MAXA : ACK_TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EJECT     = 3'd1,
    WAIT_SEEN = 3'd2,
    GAP       = 3'd3,
    DONE      = 3'd4,
    FAULT     = 3'd5
  } state_t;

  state_t        state;
  state_t        nextState;
  logic [CW-1:0] cnt;

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (refundReq) nextState = (refundQty != '0) ? EJECT : DONE;
      end
      EJECT: begin
        if (cnt == PULSE_LAST) nextState = WAIT_SEEN;
      end
      WAIT_SEEN: begin
        // a confirmation on the last timeout cycle still counts
        if (coinSeen)             nextState = (remaining == CNT_W'(1)) ? DONE : GAP;
        else if (cnt == ACK_LAST) nextState = FAULT;
      end
      GAP: begin
        if (cnt == GAP_LAST) nextState = EJECT;
      end
      DONE:    nextState = IDLE;
      FAULT: begin
        if (clrFault) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      cnt       <= '0;
      remaining <= '0;
    end else begin
      state <= nextState;
      cnt   <= (nextState != state) ? '0 : cnt + CW'(1);
      case (state)
        IDLE: begin
          if (refundReq && refundQty != '0) remaining <= refundQty;
        end
        WAIT_SEEN: begin
          if (coinSeen) remaining <= remaining - CNT_W'(1);
        end
        FAULT: begin
          if (clrFault) remaining <= '0;
        end
        default: remaining <= remaining;
      endcase
    end
  end

  // outputs decode the state register directly, so reset clears them without an edge
  assign eject = (state == EJECT);
  assign busy  = (state == EJECT) || (state == WAIT_SEEN) || (state == GAP) || (state == DONE);
  assign done  = (state == DONE);
  assign fault = (state == FAULT);

endmodule

// File: tb/tb_coin_refunder.sv
// Bench for coin_refunder: vector table of refund scenarios driven through a cycle loop with a scoreboard, plus reset corner cases.
module tb_coin_refunder;

  localparam int CNT_W       = 4;
  localparam int PULSE_CYC   = 4;
  localparam int GAP_CYC     = 8;
  localparam int ACK_TIMEOUT = 16;
  localparam int NEVER       = 99;
  localparam int BUDGET      = 800;

  logic             clock = 1'b0;
  logic             resetN;
  logic             refundReq;
  logic [CNT_W-1:0] refundQty;
  logic             coinSeen;
  logic             clrFault;
  logic             eject;
  logic             busy;
  logic             done;
  logic             fault;
  logic [CNT_W-1:0] remaining;

  int nTests = 0;
  int nFail  = 0;

  coin_refunder #(
    .CNT_W(CNT_W), .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clock(clock), .resetN(resetN), .refundReq(refundReq), .refundQty(refundQty),
    .coinSeen(coinSeen), .clrFault(clrFault), .eject(eject), .busy(busy),
    .done(done), .fault(fault), .remaining(remaining)
  );

  always #5 clock = ~clock;

  typedef struct {
    int qty;
    int seenK;
    bit noise;
    int expEjects;
    bit expFault;
    int expRem;
  } vec_t;

  typedef struct {
    int ejects;
    bit isFault;
    int rem;
  } exp_t;

  exp_t  sb[$];
  vec_t  vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic scoreCompare(input int idx, input int ejects, input bit isFault);
    exp_t e;
    if (sb.size() == 0) begin
      check($sformatf("v%0d scoreboard empty", idx), 0, 1);
    end else begin
      e = sb.pop_front();
      check($sformatf("v%0d eject count", idx), ejects, e.ejects);
      check($sformatf("v%0d fault outcome", idx), {31'd0, isFault}, {31'd0, e.isFault});
      check($sformatf("v%0d final remaining", idx), remaining, e.rem);
    end
  endtask

  task automatic runVec(input vec_t v, input int idx);
    int   ejects   = 0;
    int   hiCnt    = 0;
    int   loCnt    = 0;
    int   waitIdx  = 0;
    int   cyc      = 0;
    int   firstIdx = -1;
    int   expRem;
    bit   waiting  = 1'b0;
    bit   decNext  = 1'b0;
    bit   prevEj   = 1'b0;
    bit   finished = 1'b0;
    bit   gapNoise = 1'b0;
    exp_t e;
    e.ejects = v.expEjects; e.isFault = v.expFault; e.rem = v.expRem;
    sb.push_back(e);

    @(negedge clock);
    refundReq = 1'b1;
    refundQty = v.qty[CNT_W-1:0];
    expRem    = v.qty;

    while (!finished && cyc < BUDGET) begin
      @(negedge clock);
      cyc++;
      refundReq = 1'b0;
      coinSeen  = 1'b0;
      if (decNext) begin expRem--; decNext = 1'b0; end
      check($sformatf("v%0d remaining c%0d", idx, cyc), remaining, expRem);
      if (firstIdx < 0 && (eject || done || fault)) firstIdx = cyc;

      if (done) begin
        finished = 1'b1;
        check($sformatf("v%0d busy on done", idx), busy, 1);
        scoreCompare(idx, ejects, 1'b0);
        @(negedge clock);
        check($sformatf("v%0d done one cycle", idx), done, 0);
        check($sformatf("v%0d busy after done", idx), busy, 0);
        check($sformatf("v%0d eject after done", idx), eject, 0);
      end else if (fault) begin
        finished = 1'b1;
        check($sformatf("v%0d fault timing", idx), waitIdx, ACK_TIMEOUT);
        check($sformatf("v%0d busy in fault", idx), busy, 0);
        check($sformatf("v%0d eject in fault", idx), eject, 0);
        scoreCompare(idx, ejects, 1'b1);
        refundReq = 1'b1;
        refundQty = 4'd3;
        repeat (3) @(negedge clock);
        check($sformatf("v%0d fault holds", idx), fault, 1);
        check($sformatf("v%0d req ignored in fault", idx), {busy, eject}, 0);
        check($sformatf("v%0d fault keeps remaining", idx), remaining, v.expRem);
        refundReq = 1'b0;
        clrFault  = 1'b1;
        @(negedge clock);
        clrFault  = 1'b0;
        check($sformatf("v%0d fault cleared", idx), fault, 0);
        check($sformatf("v%0d remaining cleared", idx), remaining, 0);
        check($sformatf("v%0d idle after clear", idx), busy, 0);
      end else begin
        check($sformatf("v%0d busy c%0d", idx, cyc), busy, 1);
        if (eject) begin
          if (!prevEj && ejects > 0)
            check($sformatf("v%0d gap before coin %0d", idx, ejects + 1), loCnt, v.seenK + 1 + GAP_CYC);
          hiCnt++;
          if (v.noise && hiCnt == 2) begin
            refundReq = 1'b1;
            refundQty = 4'd5;
            coinSeen  = 1'b1;
          end
        end else begin
          if (prevEj) begin
            check($sformatf("v%0d pulse width %0d", idx, ejects + 1), hiCnt, PULSE_CYC);
            ejects++;
            hiCnt   = 0;
            loCnt   = 0;
            waiting = 1'b1;
            waitIdx = 0;
          end
          loCnt++;
          if (waiting) begin
            if (waitIdx == v.seenK) begin
              coinSeen = 1'b1;
              waiting  = 1'b0;
              decNext  = 1'b1;
              gapNoise = v.noise;
            end
            waitIdx++;
          end else if (gapNoise) begin
            coinSeen = 1'b1;
            gapNoise = 1'b0;
          end
        end
      end
      prevEj = eject;
    end

    coinSeen = 1'b0;
    if (!finished) check($sformatf("v%0d timeout waiting for done/fault", idx), 0, 1);
    check($sformatf("v%0d first response latency", idx), firstIdx, 1);
  endtask

  initial begin
    vecs[0] = '{qty: 3,  seenK: 2,     noise: 1'b0, expEjects: 3,  expFault: 1'b0, expRem: 0};
    vecs[1] = '{qty: 0,  seenK: 0,     noise: 1'b0, expEjects: 0,  expFault: 1'b0, expRem: 0};
    vecs[2] = '{qty: 2,  seenK: NEVER, noise: 1'b0, expEjects: 1,  expFault: 1'b1, expRem: 2};
    vecs[3] = '{qty: 1,  seenK: 3,     noise: 1'b0, expEjects: 1,  expFault: 1'b0, expRem: 0};
    vecs[4] = '{qty: 1,  seenK: 15,    noise: 1'b0, expEjects: 1,  expFault: 1'b0, expRem: 0};
    vecs[5] = '{qty: 1,  seenK: 16,    noise: 1'b0, expEjects: 1,  expFault: 1'b1, expRem: 1};
    vecs[6] = '{qty: 1,  seenK: 0,     noise: 1'b1, expEjects: 1,  expFault: 1'b0, expRem: 0};
    vecs[7] = '{qty: 2,  seenK: 1,     noise: 1'b1, expEjects: 2,  expFault: 1'b0, expRem: 0};
    vecs[8] = '{qty: 15, seenK: 0,     noise: 1'b0, expEjects: 15, expFault: 1'b0, expRem: 0};

    resetN    = 1'b0;
    refundReq = 1'b0;
    refundQty = '0;
    coinSeen  = 1'b0;
    clrFault  = 1'b0;
    repeat (3) @(negedge clock);
    check("reset outputs", {eject, busy, done, fault}, 0);
    check("reset remaining", remaining, 0);
    resetN = 1'b1;
    repeat (2) @(negedge clock);
    check("idle without request", {eject, busy, done, fault}, 0);

    for (int i = 0; i < 9; i++) runVec(vecs[i], i);

    // asynchronous reset on the second eject cycle
    @(negedge clock);
    refundReq = 1'b1;
    refundQty = 4'd3;
    @(negedge clock);
    refundReq = 1'b0;
    check("rst: eject cycle 1", eject, 1);
    @(negedge clock);
    check("rst: eject cycle 2", eject, 1);
    check("rst: remaining loaded", remaining, 3);
    #2 resetN = 1'b0;
    #1;
    check("rst: eject drops without edge", eject, 0);
    check("rst: busy drops without edge", busy, 0);
    check("rst: remaining clears without edge", remaining, 0);
    @(negedge clock);
    resetN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check($sformatf("rst: idle after release c%0d", k), {eject, busy, done, fault}, 0);
    end
    runVec(vecs[6], 9);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

endmodule
